// File: rtl/farm_pkg.sv
// farm_pkg: shared constants and types for the farm sensor monitor.
//   CFG_SEL_MIN / CFG_SEL_MAX : cfg_sel encodings for threshold writes
//   THR_MIN_FILL / THR_MAX_FILL : reset fill bit for min / max thresholds
//   ch_idx_t : channel index wide enough for any legal NUM_CH (2..8),
//              used for range-checking narrow channel ports
package farm_pkg;
  localparam logic CFG_SEL_MIN  = 1'b0;
  localparam logic CFG_SEL_MAX  = 1'b1;
  localparam logic THR_MIN_FILL = 1'b0;
  localparam logic THR_MAX_FILL = 1'b1;

  typedef logic [3:0] ch_idx_t;
endpackage

// File: rtl/farm_avg_channel.sv
// farm_avg_channel: moving-average datapath for one sensor channel.
//   clk, rst_n   : clock, async active-low reset
//   accept       : sample for this channel accepted this cycle
//   sample_data  : raw reading
//   avg          : windowed average including sample_data (combinational)
//   filled       : window has held a full set of samples before this cycle
module farm_avg_channel #(
  parameter int DATA_W   = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept,
  input  logic [DATA_W-1:0] sample_data,
  output logic [DATA_W-1:0] avg,
  output logic              filled
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = DATA_W + AVG_LOG2;

  logic [DATA_W-1:0]   buf_q [DEPTH];
  logic [AVG_LOG2-1:0] ptr;
  logic [AVG_LOG2-1:0] fill_cnt;
  logic [SW-1:0]       sum;
  logic [SW-1:0]       new_sum;

  // Sum of the window after replacing the oldest entry; cannot overflow SW bits.
  always_comb begin
    new_sum = sum - SW'(buf_q[ptr]) + SW'(sample_data);
    avg     = new_sum[SW-1:AVG_LOG2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      ptr      <= '0;
      fill_cnt <= '0;
      sum      <= '0;
      filled   <= 1'b0;
    end else if (accept) begin
      buf_q[ptr] <= sample_data;
      ptr        <= ptr + 1'b1;
      sum        <= new_sum;
      if (!filled) begin
        fill_cnt <= fill_cnt + 1'b1;
        if (fill_cnt == '1) filled <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/farm_sensor_monitor.sv
// farm_sensor_monitor: multi-channel sensor monitor with moving average,
// programmable min/max thresholds, persistence-filtered alerts with
// hysteresis, sticky acknowledgeable alarms and a buzzer.
//   clk, rst_n                         : clock, async active-low reset
//   ena                                : global enable
//   sample_valid/sample_ch/sample_data : time-multiplexed sample input
//   cfg_we/cfg_ch/cfg_sel/cfg_data     : threshold write (sel 0=min, 1=max)
//   ack                                : per-channel latched-alarm clear
//   avg_valid/avg_ch/avg_data          : registered average result
//   alert_vec                          : live filtered alert per channel
//   alarm_latched                      : sticky alarm per channel
//   buzzer                             : OR of alert_vec and alarm_latched
module farm_sensor_monitor
  import farm_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 8,
  parameter int AVG_LOG2 = 2,
  parameter int PERSIST  = 3,
  parameter int HYST     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      sample_valid,
  input  logic [$clog2(NUM_CH)-1:0] sample_ch,
  input  logic [DATA_W-1:0]         sample_data,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic                      cfg_sel,
  input  logic [DATA_W-1:0]         cfg_data,
  input  logic [NUM_CH-1:0]         ack,
  output logic                      avg_valid,
  output logic [$clog2(NUM_CH)-1:0] avg_ch,
  output logic [DATA_W-1:0]         avg_data,
  output logic [NUM_CH-1:0]         alert_vec,
  output logic [NUM_CH-1:0]         alarm_latched,
  output logic                      buzzer
);
  localparam int CW = $clog2(NUM_CH);
  localparam logic [3:0]      PERS_X = 4'(PERSIST);
  localparam logic [DATA_W:0] HYST_X = (DATA_W+1)'(HYST);

  logic              sample_ok;
  logic              cfg_ok;
  logic [NUM_CH-1:0] ch_acc;
  logic [NUM_CH-1:0] ch_filled;
  logic [DATA_W-1:0] ch_avg [NUM_CH];

  logic [DATA_W-1:0] min_q  [NUM_CH];
  logic [DATA_W-1:0] max_q  [NUM_CH];
  logic [3:0]        pers_q [NUM_CH];
  logic [3:0]        pers_nxt [NUM_CH];
  logic [NUM_CH-1:0] alert_nxt;
  logic [NUM_CH-1:0] alert_d;
  logic [DATA_W-1:0] avg_sel;

  assign sample_ok = ena && sample_valid && (ch_idx_t'(sample_ch) < ch_idx_t'(NUM_CH));
  assign cfg_ok    = ena && cfg_we && (ch_idx_t'(cfg_ch) < ch_idx_t'(NUM_CH));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_acc[g] = sample_ok && (sample_ch == CW'(g));
    farm_avg_channel #(
      .DATA_W  (DATA_W),
      .AVG_LOG2(AVG_LOG2)
    ) u_avg (
      .clk        (clk),
      .rst_n      (rst_n),
      .accept     (ch_acc[g]),
      .sample_data(sample_data),
      .avg        (ch_avg[g]),
      .filled     (ch_filled[g])
    );
  end

  // Threshold evaluation against the thresholds registered before this cycle.
  always_comb begin
    pers_nxt  = pers_q;
    alert_nxt = alert_vec;
    avg_sel   = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (ch_acc[c]) begin
        avg_sel = ch_avg[c];
        if (ch_filled[c]) begin
          if (ch_avg[c] < min_q[c] || ch_avg[c] > max_q[c]) begin
            if (pers_q[c] < PERS_X) pers_nxt[c] = pers_q[c] + 4'd1;
            if (pers_nxt[c] == PERS_X) alert_nxt[c] = 1'b1;
          end else begin
            pers_nxt[c] = '0;
            // Clear band is empty when max < HYST; checked explicitly to avoid wrap.
            if (({1'b0, max_q[c]} >= HYST_X) &&
                ({1'b0, min_q[c]} + HYST_X <= {1'b0, ch_avg[c]}) &&
                ({1'b0, ch_avg[c]} <= {1'b0, max_q[c]} - HYST_X))
              alert_nxt[c] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        min_q[c]  <= {DATA_W{THR_MIN_FILL}};
        max_q[c]  <= {DATA_W{THR_MAX_FILL}};
        pers_q[c] <= '0;
      end
      alert_vec     <= '0;
      alert_d       <= '0;
      alarm_latched <= '0;
      avg_valid     <= 1'b0;
      avg_ch        <= '0;
      avg_data      <= '0;
    end else if (ena) begin
      avg_valid <= sample_ok;
      if (sample_ok) begin
        avg_ch   <= sample_ch;
        avg_data <= avg_sel;
      end
      pers_q    <= pers_nxt;
      alert_vec <= alert_nxt;
      alert_d   <= alert_vec;
      // A rising alert edge wins over a same-cycle ack.
      alarm_latched <= (alarm_latched & ~ack) | (alert_vec & ~alert_d);
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (cfg_ok && cfg_ch == CW'(c)) begin
          if (cfg_sel == CFG_SEL_MIN) min_q[c] <= cfg_data;
          else                        max_q[c] <= cfg_data;
        end
      end
    end else begin
      avg_valid <= 1'b0;
    end
  end

  assign buzzer = |(alert_vec | alarm_latched);
endmodule

// File: tb/tb_farm_sensor_monitor.sv
// tb_farm_sensor_monitor: directed plus randomized checks of the sensor
// monitor against a queue-based reference model. A second instance with
// NUM_CH=3 shares the inputs so channel index 3 exercises the out-of-range path.
module tb_farm_sensor_monitor;
  localparam int NUM_CH = 4, DATA_W = 8, AVG_LOG2 = 2, PERSIST = 3, HYST = 4;
  localparam int WIN = 1 << AVG_LOG2;

  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0, sample_valid = 1'b0;
  logic [1:0] sample_ch = '0, cfg_ch = '0;
  logic [7:0] sample_data = '0, cfg_data = '0;
  logic       cfg_we = 1'b0, cfg_sel = 1'b0;
  logic [3:0] ack = '0;

  logic       avg_valid, buzzer;
  logic [1:0] avg_ch;
  logic [7:0] avg_data;
  logic [3:0] alert_vec, alarm_latched;

  logic       avg_valid3, buzzer3;
  logic [1:0] avg_ch3;
  logic [7:0] avg_data3;
  logic [2:0] alert_vec3, alarm_latched3;

  farm_sensor_monitor #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2),
                        .PERSIST(PERSIST), .HYST(HYST)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sample_valid(sample_valid),
    .sample_ch(sample_ch), .sample_data(sample_data), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .ack(ack),
    .avg_valid(avg_valid), .avg_ch(avg_ch), .avg_data(avg_data),
    .alert_vec(alert_vec), .alarm_latched(alarm_latched), .buzzer(buzzer));

  farm_sensor_monitor #(.NUM_CH(3), .DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2),
                        .PERSIST(PERSIST), .HYST(HYST)) dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sample_valid(sample_valid),
    .sample_ch(sample_ch), .sample_data(sample_data), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .ack(ack[2:0]),
    .avg_valid(avg_valid3), .avg_ch(avg_ch3), .avg_data(avg_data3),
    .alert_vec(alert_vec3), .alarm_latched(alarm_latched3), .buzzer(buzzer3));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each channel remembers its last WIN samples.
  int q [NUM_CH][$];
  int cnt [NUM_CH], mn [NUM_CH], mx [NUM_CH], pers [NUM_CH];
  bit al [NUM_CH], ald [NUM_CH], lat [NUM_CH];
  bit exp_valid, exp3_valid;
  int exp_ch, exp_data, exp3_ch, exp3_data;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      q[c].delete();
      cnt[c] = 0; mn[c] = 0; mx[c] = 255; pers[c] = 0;
      al[c] = 0; ald[c] = 0; lat[c] = 0;
    end
    exp_valid = 0; exp_ch = 0; exp_data = 0;
    exp3_valid = 0; exp3_ch = 0; exp3_data = 0;
  endtask

  task automatic model_edge();
    int c, s, avg;
    bit was_filled;
    if (!ena) begin
      exp_valid = 0; exp3_valid = 0;
      return;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      bit nl;
      nl = (lat[k] && !ack[k]) || (al[k] && !ald[k]);
      ald[k] = al[k];
      lat[k] = nl;
    end
    exp_valid  = sample_valid;
    exp3_valid = sample_valid && (sample_ch < 3);
    if (sample_valid) begin
      c = int'(sample_ch);
      q[c].push_back(int'(sample_data));
      if (q[c].size() > WIN) void'(q[c].pop_front());
      s = 0;
      foreach (q[c][k]) s += q[c][k];
      avg = s / WIN;
      was_filled = (cnt[c] >= WIN);
      if (cnt[c] < WIN) cnt[c]++;
      exp_ch = c; exp_data = avg;
      if (c < 3) begin exp3_ch = c; exp3_data = avg; end
      if (was_filled) begin
        if (avg < mn[c] || avg > mx[c]) begin
          if (pers[c] < PERSIST) pers[c]++;
          if (pers[c] >= PERSIST) al[c] = 1;
        end else begin
          pers[c] = 0;
          if (avg >= mn[c] + HYST && avg <= mx[c] - HYST) al[c] = 0;
        end
      end
    end
    if (cfg_we) begin
      if (cfg_sel) mx[int'(cfg_ch)] = int'(cfg_data);
      else         mn[int'(cfg_ch)] = int'(cfg_data);
    end
  endtask

  function automatic logic [3:0] pack(input bit v [NUM_CH]);
    logic [3:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = v[c];
    return r;
  endfunction

  task automatic compare();
    logic [3:0] ea, el;
    ea = pack(al); el = pack(lat);
    check("avg_valid", avg_valid, exp_valid);
    check("avg_ch", avg_ch, exp_ch);
    check("avg_data", avg_data, exp_data);
    check("alert_vec", alert_vec, ea);
    check("alarm_latched", alarm_latched, el);
    check("buzzer", buzzer, |(ea | el));
    check("d3_avg_valid", avg_valid3, exp3_valid);
    check("d3_avg_ch", avg_ch3, exp3_ch);
    check("d3_avg_data", avg_data3, exp3_data);
    check("d3_alert_vec", alert_vec3, ea[2:0]);
    check("d3_alarm_latched", alarm_latched3, el[2:0]);
    check("d3_buzzer", buzzer3, |(ea[2:0] | el[2:0]));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_edge();
    #1;
    compare();
    sample_valid = 0; cfg_we = 0; ack = '0;
  endtask

  task automatic sample(input int c, input int d);
    sample_valid = 1; sample_ch = 2'(c); sample_data = 8'(d);
    step();
  endtask

  task automatic cfg_set(input int c, input bit sel, input int d);
    cfg_we = 1; cfg_ch = 2'(c); cfg_sel = sel; cfg_data = 8'(d);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_avg_valid"}, avg_valid, 0);
    check({tag, "_avg_ch"}, avg_ch, 0);
    check({tag, "_avg_data"}, avg_data, 0);
    check({tag, "_alert"}, alert_vec, 0);
    check({tag, "_latched"}, alarm_latched, 0);
    check({tag, "_buzzer"}, buzzer, 0);
    check({tag, "_d3_alert"}, alert_vec3, 0);
    check({tag, "_d3_avg_valid"}, avg_valid3, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wv [4] = '{10, 20, 30, 40};
    int we [4] = '{2, 7, 15, 25};
    model_reset();
    ena = 1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1;

    // Warm-up on ch0
    for (int i = 0; i < 4; i++) begin
      sample(0, wv[i]);
      check("warm_avg", avg_data, we[i]);
      check("warm_valid", avg_valid, 1);
      check("warm_alert", alert_vec[0], 0);
    end

    // Persistence on ch1
    cfg_set(1, 0, 100); step();
    cfg_set(1, 1, 160); step();
    for (int i = 1; i <= 7; i++) begin
      sample(1, 50);
      check("pers_alert", alert_vec[1], (i == 7));
    end
    step();
    check("latch_set", alarm_latched[1], 1);
    check("buzzer_on", buzzer, 1);

    // Hysteresis
    repeat (4) sample(1, 102);
    check("hyst_avg", avg_data, 102);
    check("hyst_hold", alert_vec[1], 1);
    sample(1, 130);
    check("hyst_avg2", avg_data, 109);
    check("hyst_clear", alert_vec[1], 0);
    step();
    check("latch_hold", alarm_latched[1], 1);
    ack = 4'b0010; step();
    check("ack_clear", alarm_latched[1], 0);

    // Ack colliding with a fresh rising edge
    repeat (3) sample(1, 50);
    check("realert", alert_vec[1], 1);
    ack = 4'b0010; step();
    check("ack_vs_set", alarm_latched[1], 1);

    // Interleaved ch2/ch3 with same-cycle cfg write on ch2
    for (int i = 0; i < 4; i++) begin sample(2, 100); sample(3, 100); end
    cfg_set(2, 1, 50); sample(2, 100);
    check("cfg_old_thr", alert_vec[2], 0);
    for (int i = 0; i < 3; i++) begin sample(3, 100); sample(2, 100); end
    check("cfg_new_thr", alert_vec[2], 1);
    check("ch3_indep", alert_vec[3], 0);

    // Out-of-range channel on the 3-channel instance, and ena low
    sample(3, 7);
    check("oor_ch", avg_valid3, 0);
    ena = 0; sample(0, 200); ena = 1;
    check("ena_low", avg_valid, 0);

    // Randomized traffic with one mid-stream async reset
    for (int i = 0; i < 800; i++) begin
      ena = ($urandom_range(0, 9) != 0);
      sample_valid = ($urandom_range(0, 9) < 7);
      sample_ch = 2'($urandom_range(0, 3));
      sample_data = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) cfg_set($urandom_range(0, 3), 1'($urandom), $urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) ack = 4'($urandom);
      step();
      if (i == 400) begin
        #3 rst_n = 0;
        #1 check_all_zero("midrst");
        model_reset();
        #3 rst_n = 1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
